// File: rtl/uart_rx.sv
// 8N1 UART receiver with two-flop input synchronizer and mid-bit sampling.
// Pulses done on a good frame, frame_error on a low stop bit.
module uart_rx #(
    parameter int baudRate = 9600,
    parameter int clkFreq  = 132000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       signal,
    output logic [7:0] data,
    output logic       done,
    output logic       frame_error,
    output logic       busy
);

    localparam int N  = clkFreq / baudRate;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] HALF_T = CW'(H);
    localparam logic [CW-1:0] FULL_T = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            sync1;
    logic            rx_s;
    logic [CW-1:0]   count;
    logic [2:0]      index;
    logic [7:0]      shift;
    logic            wait_high;
    logic            start_hit;
    logic            bit_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= signal;
            rx_s  <= sync1;
        end
    end

    // Counting 0..N-1 makes every bit span exactly N cycles after the start sample.
    assign start_hit = (count == HALF_T);
    assign bit_hit   = (count == FULL_T);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (!rx_s && !wait_high) begin
                    state_n = START_BIT;
                end
            end
            START_BIT: begin
                if (start_hit) begin
                    state_n = rx_s ? IDLE : DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (bit_hit && index == 3'd7) begin
                    state_n = STOP_BIT;
                end
            end
            STOP_BIT: begin
                if (bit_hit) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            index       <= '0;
            shift       <= '0;
            data        <= '0;
            done        <= 1'b0;
            frame_error <= 1'b0;
            wait_high   <= 1'b0;
        end else begin
            done        <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    index <= '0;
                    if (rx_s) begin
                        wait_high <= 1'b0;
                    end
                end
                START_BIT: begin
                    count <= start_hit ? '0 : count + 1'b1;
                end
                DATA_BITS: begin
                    if (bit_hit) begin
                        shift[index] <= rx_s;
                        count        <= '0;
                        index        <= index + 3'd1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (bit_hit) begin
                        count <= '0;
                        if (rx_s) begin
                            data <= shift;
                            done <= 1'b1;
                        end else begin
                            // A held-low line must go high before the next start.
                            frame_error <= 1'b1;
                            wait_high   <= 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    count <= '0;
                    index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at N=16, H=8: vector table, glitch,
// mid-frame reset, break and a 256-byte back-to-back stream.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       signal = 1'b1;
    logic [7:0] data;
    logic       done;
    logic       frame_error;
    logic       busy;

    uart_rx #(.baudRate(10), .clkFreq(160)) dut (
        .clk(clk),
        .reset(reset),
        .signal(signal),
        .data(data),
        .done(done),
        .frame_error(frame_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         exp_done;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    int         n_vec = 0;
    int         n_bad = 0;
    int         n_done = 0;
    int         n_fe = 0;
    logic       prev_done = 1'b0;
    logic [7:0] rx_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                n_done++;
                rx_q.push_back(data);
                check("busy_low_at_done", 32'(busy), 32'd0);
                check("done_one_cycle", 32'(prev_done), 32'd0);
                check("done_fe_exclusive", 32'(frame_error), 32'd0);
            end
            if (frame_error) n_fe++;
        end
        prev_done = done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        signal = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            signal = b[i];
            tick(16);
        end
        signal = stop;
        tick(16);
        signal = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[6];
        int         d0;
        int         f0;
        int         q0;
        logic [7:0] data0;

        tbl[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        tbl[1] = '{8'h55, 1'b0, 0, 1, 8'hA5};
        tbl[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        tbl[4] = '{8'h01, 1'b0, 0, 1, 8'hFF};
        tbl[5] = '{8'h80, 1'b1, 1, 0, 8'h80};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fe", 32'(frame_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(5);

        for (int v = 0; v < 6; v++) begin
            d0 = n_done;
            f0 = n_fe;
            send(tbl[v].b, tbl[v].stop);
            tick(4);
            check($sformatf("vec%0d_done", v), 32'(n_done - d0), 32'(tbl[v].exp_done));
            check($sformatf("vec%0d_fe", v), 32'(n_fe - f0), 32'(tbl[v].exp_fe));
            check($sformatf("vec%0d_data", v), 32'(data), 32'(tbl[v].exp_data));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
        end

        q0 = rx_q.size();
        send(8'h3C, 1'b1);
        send(8'hFF, 1'b1);
        tick(4);
        check("b2b_count", 32'(rx_q.size() - q0), 32'd2);
        check("b2b_first", 32'(rx_q[q0]), 32'h3C);
        check("b2b_second", 32'(rx_q[q0 + 1]), 32'hFF);

        d0 = n_done;
        f0 = n_fe;
        data0 = data;
        signal = 1'b0;
        tick(4);
        check("glitch_busy_high", 32'(busy), 32'd1);
        tick(1);
        signal = 1'b1;
        tick(30);
        check("glitch_done", 32'(n_done - d0), 32'd0);
        check("glitch_fe", 32'(n_fe - f0), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_data", 32'(data), 32'(data0));

        d0 = n_done;
        f0 = n_fe;
        signal = 1'b0;
        tick(16);
        signal = 1'b1;
        tick(16);
        signal = 1'b0;
        tick(32);
        tick(8);
        reset = 1'b0;
        tick(2);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(data), 32'h00);
        signal = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(20);
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        check("midrst_no_fe", 32'(n_fe - f0), 32'd0);
        send(8'h81, 1'b1);
        tick(4);
        check("midrst_done", 32'(n_done - d0), 32'd1);
        check("midrst_data2", 32'(data), 32'h81);

        d0 = n_done;
        f0 = n_fe;
        signal = 1'b0;
        tick(200);
        check("break_fe", 32'(n_fe - f0), 32'd1);
        check("break_done", 32'(n_done - d0), 32'd0);
        check("break_busy", 32'(busy), 32'd0);
        tick(100);
        check("break_fe_hold", 32'(n_fe - f0), 32'd1);
        check("break_busy_hold", 32'(busy), 32'd0);
        check("break_data", 32'(data), 32'h81);
        signal = 1'b1;
        tick(5);
        send(8'h42, 1'b1);
        tick(4);
        check("after_break_done", 32'(n_done - d0), 32'd1);
        check("after_break_data", 32'(data), 32'h42);

        q0 = rx_q.size();
        f0 = n_fe;
        for (int b = 0; b < 256; b++) begin
            send(8'(b), 1'b1);
        end
        tick(4);
        check("stream_count", 32'(rx_q.size() - q0), 32'd256);
        check("stream_fe", 32'(n_fe - f0), 32'd0);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("stream_byte%0d", i), 32'(rx_q[q0 + i]), 32'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
